// File: rtl/alu_seq_ctrl.sv
// Sequences a wide ALU operation through a shared DWIDTH-bit slice, one slice per cycle,
// starting with the least significant slice and chaining the carry in arithmetic mode.
module alu_seq_ctrl #(
  parameter int DWIDTH = 8,
  parameter int NSLICE = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DWIDTH*NSLICE-1:0] op1,
  input  logic [DWIDTH*NSLICE-1:0] op2,
  input  logic [2:0]               opsel,
  input  logic                     mode,
  input  logic                     cin,
  output logic                     busy,
  output logic                     done,
  output logic [DWIDTH*NSLICE-1:0] result,
  output logic                     c_flag,
  output logic                     z_flag,
  output logic                     o_flag,
  output logic                     s_flag,
  output logic [DWIDTH-1:0]        alu_op1,
  output logic [DWIDTH-1:0]        alu_op2,
  output logic [2:0]               alu_opsel,
  output logic                     alu_mode,
  output logic                     alu_cin,
  input  logic [DWIDTH-1:0]        alu_result,
  input  logic                     alu_cout,
  input  logic                     alu_o_flag
);

  localparam int W  = DWIDTH * NSLICE;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    op1_q, op2_q;
  logic [2:0]      opsel_q;
  logic            mode_q;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    acc, acc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    alu_op1   = '0;
    alu_op2   = '0;
    alu_opsel = '0;
    alu_mode  = 1'b0;
    alu_cin   = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        alu_op1   = op1_q[idx*DWIDTH +: DWIDTH];
        alu_op2   = op2_q[idx*DWIDTH +: DWIDTH];
        alu_opsel = opsel_q;
        alu_mode  = mode_q;
        alu_cin   = carry;
        if (idx == LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Partial results build up in acc so the visible result stays stable until the final capture
  always_comb begin
    acc_nxt = acc;
    acc_nxt[idx*DWIDTH +: DWIDTH] = alu_result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_q   <= '0;
      op2_q   <= '0;
      opsel_q <= '0;
      mode_q  <= 1'b0;
      idx     <= '0;
      carry   <= 1'b0;
      acc     <= '0;
      result  <= '0;
      c_flag  <= 1'b0;
      z_flag  <= 1'b0;
      o_flag  <= 1'b0;
      s_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op1_q   <= op1;
          op2_q   <= op2;
          opsel_q <= opsel;
          mode_q  <= mode;
          idx     <= '0;
          carry   <= mode ? 1'b0 : cin;
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= mode_q ? 1'b0 : alu_cout;
          if (idx == LAST) begin
            result <= acc_nxt;
            c_flag <= mode_q ? 1'b0 : alu_cout;
            o_flag <= mode_q ? 1'b0 : alu_o_flag;
            s_flag <= alu_result[DWIDTH-1];
            z_flag <= ~|acc_nxt;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: a behavioural byte-slice ALU answers the DUT, and a full-width
// arithmetic model predicts result and flags for directed and random operations.
module tb_alu_seq_ctrl;

  localparam int DW = 8;
  localparam int NS = 16;
  localparam int W  = DW * NS;

  logic          clk, rst, start, mode, cin;
  logic [W-1:0]  op1, op2, result;
  logic [2:0]    opsel, alu_opsel;
  logic          busy, done, c_flag, z_flag, o_flag, s_flag;
  logic [DW-1:0] alu_op1, alu_op2, alu_result;
  logic          alu_mode, alu_cin, alu_cout, alu_o_flag;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int done_cnt  = 0;
  int slices;
  bit force_cout = 0;
  logic cin_hist [NS];

  alu_seq_ctrl #(.DWIDTH(DW), .NSLICE(NS)) dut (
    .clk(clk), .rst(rst), .start(start), .op1(op1), .op2(op2), .opsel(opsel),
    .mode(mode), .cin(cin), .busy(busy), .done(done), .result(result),
    .c_flag(c_flag), .z_flag(z_flag), .o_flag(o_flag), .s_flag(s_flag),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opsel(alu_opsel), .alu_mode(alu_mode),
    .alu_cin(alu_cin), .alu_result(alu_result), .alu_cout(alu_cout), .alu_o_flag(alu_o_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte slice: add/sub (opsel[0]) in arithmetic mode, and/or/xor/pass in logic mode
  always_comb begin
    logic [7:0] bb;
    logic [8:0] s9;
    bb = alu_opsel[0] ? ~alu_op2 : alu_op2;
    s9 = {1'b0, alu_op1} + {1'b0, bb} + {8'd0, alu_cin};
    if (!alu_mode) begin
      alu_result = s9[7:0];
      alu_cout   = s9[8];
      alu_o_flag = (alu_op1[7] == bb[7]) && (s9[7] != alu_op1[7]);
    end else begin
      case (alu_opsel)
        3'd0:    alu_result = alu_op1 & alu_op2;
        3'd1:    alu_result = alu_op1 | alu_op2;
        3'd2:    alu_result = alu_op1 ^ alu_op2;
        default: alu_result = alu_op1;
      endcase
      alu_cout   = force_cout;
      alu_o_flag = force_cout;
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  // Returns {c, z, o, s, result} for the whole operand width at once
  function automatic logic [W+3:0] refModel(input logic [W-1:0] a, b, input logic [2:0] sel,
                                            input logic md, ci);
    logic [W-1:0] bb, r;
    logic [W:0]   s;
    logic         c, o;
    c = 1'b0;
    o = 1'b0;
    if (!md) begin
      bb = sel[0] ? ~b : b;
      s  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
      r  = s[W-1:0];
      c  = s[W];
      o  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      case (sel)
        3'd0:    r = a & b;
        3'd1:    r = a | b;
        3'd2:    r = a ^ b;
        default: r = a;
      endcase
    end
    return {c, (r == '0), o, r[W-1], r};
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    check_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic int cinOnes();
    int n = 0;
    for (int i = 0; i < NS; i++) if (cin_hist[i] === 1'b1) n++;
    return n;
  endfunction

  // Called at a negedge; accepts on the next posedge, scrambles inputs, then checks everything
  task automatic applyStimulus(input logic [W-1:0] a, b, input logic [2:0] sel,
                               input logic md, ci, input bit inject);
    logic [W+3:0] exp;
    int lat, d0;
    exp = refModel(a, b, sel, md, ci);
    d0  = done_cnt;
    op1 = a; op2 = b; opsel = sel; mode = md; cin = ci; start = 1'b1;
    for (int i = 0; i < NS; i++) cin_hist[i] = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    op1 = {$urandom, $urandom, $urandom, $urandom};
    op2 = {$urandom, $urandom, $urandom, $urandom};
    opsel = 3'($urandom); mode = 1'($urandom); cin = 1'($urandom);
    lat = 1;
    slices = 0;
    while (!done && lat < 40) begin
      if (busy) begin
        if (slices < NS) cin_hist[slices] = alu_cin;
        if (inject) start = (slices == 3 || slices == 10);
        slices++;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    checkOutput("latency", W'(lat), W'(NS + 1));
    checkOutput("busy_cycles", W'(slices), W'(NS));
    checkOutput("result", result, exp[W-1:0]);
    checkOutput("c_flag", W'(c_flag), W'(exp[W+3]));
    checkOutput("z_flag", W'(z_flag), W'(exp[W+2]));
    checkOutput("o_flag", W'(o_flag), W'(exp[W+1]));
    checkOutput("s_flag", W'(s_flag), W'(exp[W]));
    checkOutput("alu_quiet_done", W'({alu_op1, alu_op2, alu_opsel, alu_mode, alu_cin}), '0);
    @(posedge clk); #1;
    checkOutput("done_pulse", W'(done), '0);
    checkOutput("result_hold", result, exp[W-1:0]);
    checkOutput("done_count", W'(done_cnt - d0), W'(1));
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; op1 = '0; op2 = '0; opsel = '0; mode = 1'b0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", W'({busy, done, c_flag, z_flag, o_flag, s_flag,
                alu_op1, alu_op2, alu_opsel, alu_mode, alu_cin}), '0);
    checkOutput("reset_result", result, '0);

    @(negedge clk);
    rst = 1'b0;
    $display("[TB] all ones plus one");
    applyStimulus({W{1'b1}}, W'(1), 3'd0, 1'b0, 1'b0, 0);

    @(negedge clk);
    $display("[TB] signed overflow into MSB");
    applyStimulus({8'h7F, {15{8'hFF}}}, W'(1), 3'd0, 1'b0, 1'b0, 0);

    @(negedge clk);
    $display("[TB] carry-in only");
    applyStimulus('0, '0, 3'd0, 1'b0, 1'b1, 0);
    checkOutput("cin_slice0", W'(cin_hist[0]), W'(1));
    checkOutput("cin_count", W'(cinOnes()), W'(1));

    @(negedge clk);
    $display("[TB] logic mode with forced slice carry");
    force_cout = 1'b1;
    applyStimulus({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                  3'd2, 1'b1, 1'b1, 0);
    checkOutput("logic_cin_count", W'(cinOnes()), '0);
    force_cout = 1'b0;

    @(negedge clk);
    $display("[TB] start pulses during RUN");
    applyStimulus({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                  3'd0, 1'b0, 1'b1, 1);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      applyStimulus({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                    3'($urandom_range(0, 4)), 1'($urandom), 1'($urandom), 0);
    end

    $display("[TB] reset in the middle of RUN");
    @(negedge clk);
    op1 = {$urandom, $urandom, $urandom, $urandom}; op2 = op1; opsel = 3'd0; mode = 1'b0;
    cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    checkOutput("abort_outputs", W'({busy, done, c_flag, z_flag, o_flag, s_flag,
                alu_op1, alu_op2, alu_opsel, alu_mode, alu_cin}), '0);
    checkOutput("abort_result", result, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("abort_no_done", W'(done_cnt - d0), '0);
    applyStimulus({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                  3'd1, 1'b0, 1'b1, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
